// File: rtl/ex_mdu_ctrl_if.sv
// Bundle between the EX stage, the mul/div units and the MEM hand-off for ex_mdu_ctrl.
// The slave modport is the controller's view; the master modport is its environment.
interface ex_mdu_ctrl_if #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    logic                     pipe_flush;
    logic                     ex_valid;
    logic                     ex_is_mul_inst;
    logic                     ex_is_div_inst;
    logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr;
    logic                     mul_done;
    logic                     div_done;
    logic [XLEN-1:0]          mul_res;
    logic [XLEN-1:0]          div_res;
    logic                     res_ready;
    logic                     mul_start;
    logic                     div_start;
    logic                     mdu_stall;
    logic                     mdu_res_valid;
    logic [XLEN-1:0]          mdu_res;
    logic [RF_ADDR_WIDTH-1:0] mdu_rd_addr;
    logic                     mdu_err;

    modport master (
        output pipe_flush, ex_valid, ex_is_mul_inst, ex_is_div_inst, ex_rf_waddr,
        output mul_done, div_done, mul_res, div_res, res_ready,
        input  mul_start, div_start, mdu_stall, mdu_res_valid, mdu_res, mdu_rd_addr, mdu_err
    );

    modport slave (
        input  pipe_flush, ex_valid, ex_is_mul_inst, ex_is_div_inst, ex_rf_waddr,
        input  mul_done, div_done, mul_res, div_res, res_ready,
        output mul_start, div_start, mdu_stall, mdu_res_valid, mdu_res, mdu_rd_addr, mdu_err
    );
endinterface

// File: rtl/ex_mdu_ctrl.sv
// Multiply/divide issue controller: launches one unit, stalls the front end while it runs,
// holds the result until MEM accepts it, and aborts a unit that never finishes.
module ex_mdu_ctrl #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int TIMEOUT       = 64
) (
    input logic         clk,
    input logic         rst_n,
    ex_mdu_ctrl_if.slave mdu
);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                   state;
    logic [7:0]               busy_cnt;
    logic [XLEN-1:0]          res_q;
    logic [RF_ADDR_WIDTH-1:0] rd_q;

    logic issue;
    logic is_busy;
    logic done_hit;
    logic timeout_hit;

    // Issue is gated by rst_n so launch pulses stay low while reset is held.
    always_comb begin
        issue       = rst_n && (state == IDLE) && mdu.ex_valid &&
                      (mdu.ex_is_mul_inst || mdu.ex_is_div_inst) && !mdu.pipe_flush;
        is_busy     = (state == MUL_BUSY) || (state == DIV_BUSY);
        done_hit    = ((state == MUL_BUSY) && mdu.mul_done) ||
                      ((state == DIV_BUSY) && mdu.div_done);
        timeout_hit = is_busy && !done_hit && !mdu.pipe_flush && (busy_cnt == CNT_LAST);
    end

    assign mdu.mul_start     = issue && mdu.ex_is_mul_inst;
    assign mdu.div_start     = issue && !mdu.ex_is_mul_inst && mdu.ex_is_div_inst;
    assign mdu.mdu_stall     = issue || is_busy || ((state == DONE) && !mdu.res_ready);
    assign mdu.mdu_res_valid = (state == DONE);
    assign mdu.mdu_err       = timeout_hit;
    assign mdu.mdu_res       = res_q;
    assign mdu.mdu_rd_addr   = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_cnt <= 8'd0;
            res_q    <= '0;
            rd_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        rd_q     <= mdu.ex_rf_waddr;
                        busy_cnt <= 8'd0;
                        state    <= mdu.ex_is_mul_inst ? MUL_BUSY : DIV_BUSY;
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    // Flush outranks a same-cycle done so a killed op never presents a result.
                    if (mdu.pipe_flush) begin
                        state <= IDLE;
                    end else if (done_hit) begin
                        res_q <= (state == MUL_BUSY) ? mdu.mul_res : mdu.div_res;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (mdu.pipe_flush || mdu.res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Directed bench for ex_mdu_ctrl with hand-computed expectations.
module tb_ex_mdu_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   errs;

    ex_mdu_ctrl_if #(.XLEN(32), .RF_ADDR_WIDTH(5)) bus ();

    ex_mdu_ctrl #(.XLEN(32), .RF_ADDR_WIDTH(5), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.pipe_flush     = 1'b0;
        bus.ex_valid       = 1'b0;
        bus.ex_is_mul_inst = 1'b0;
        bus.ex_is_div_inst = 1'b0;
        bus.ex_rf_waddr    = 5'd0;
        bus.mul_done       = 1'b0;
        bus.div_done       = 1'b0;
        bus.mul_res        = 32'd0;
        bus.div_res        = 32'd0;
        bus.res_ready      = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        errs  = 0;
        clr();
        rst_n = 1'b0;
        bus.ex_valid       = 1'b1;
        bus.ex_is_mul_inst = 1'b1;
        cyc();
        #1;
        chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
        chk("rst_stall", 32'(bus.mdu_stall), 32'd0);
        chk("rst_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("rst_err", 32'(bus.mdu_err), 32'd0);
        chk("rst_res", bus.mdu_res, 32'd0);
        chk("rst_rd", 32'(bus.mdu_rd_addr), 32'd0);
        clr();
        rst_n = 1'b1;
        cyc();

        // Multiply rd=5, done three cycles after issue, MEM ready
        bus.ex_valid = 1'b1; bus.ex_is_mul_inst = 1'b1; bus.ex_rf_waddr = 5'd5; bus.res_ready = 1'b1;
        #1;
        chk("mul_start_issue", 32'(bus.mul_start), 32'd1);
        chk("div_start_issue", 32'(bus.div_start), 32'd0);
        chk("stall_c0", 32'(bus.mdu_stall), 32'd1);
        cyc();
        clr(); bus.res_ready = 1'b1;
        #1;
        chk("mul_start_c1", 32'(bus.mul_start), 32'd0);
        chk("stall_c1", 32'(bus.mdu_stall), 32'd1);
        chk("valid_c1", 32'(bus.mdu_res_valid), 32'd0);
        cyc();
        #1;
        chk("stall_c2", 32'(bus.mdu_stall), 32'd1);
        cyc();
        bus.mul_done = 1'b1; bus.mul_res = 32'h0000_0015;
        #1;
        chk("stall_c3", 32'(bus.mdu_stall), 32'd1);
        cyc();
        bus.mul_done = 1'b0; bus.mul_res = 32'd0;
        #1;
        chk("valid_c4", 32'(bus.mdu_res_valid), 32'd1);
        chk("res_c4", bus.mdu_res, 32'h0000_0015);
        chk("rd_c4", 32'(bus.mdu_rd_addr), 32'd5);
        chk("stall_c4", 32'(bus.mdu_stall), 32'd0);
        cyc();
        bus.mul_done = 1'b1; bus.mul_res = 32'hFFFF_FFFF;
        #1;
        chk("valid_c5", 32'(bus.mdu_res_valid), 32'd0);
        cyc();
        clr();
        #1;
        chk("idle_done_ignored", 32'(bus.mdu_res_valid), 32'd0);
        chk("idle_res_kept", bus.mdu_res, 32'h0000_0015);
        cyc();

        // Divide rd=9 held in DONE for four cycles
        bus.ex_valid = 1'b1; bus.ex_is_div_inst = 1'b1; bus.ex_rf_waddr = 5'd9;
        #1;
        chk("div_start_issue", 32'(bus.div_start), 32'd1);
        chk("mul_start_div", 32'(bus.mul_start), 32'd0);
        cyc();
        clr();
        bus.div_done = 1'b1; bus.div_res = 32'hDEAD_BEEF;
        cyc();
        bus.div_done = 1'b0; bus.div_res = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_valid", 32'(bus.mdu_res_valid), 32'd1);
            chk("hold_stall", 32'(bus.mdu_stall), 32'd1);
            chk("hold_res", bus.mdu_res, 32'hDEAD_BEEF);
            chk("hold_rd", 32'(bus.mdu_rd_addr), 32'd9);
            cyc();
        end
        bus.res_ready = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_is_mul_inst = 1'b1; bus.ex_rf_waddr = 5'd1;
        #1;
        chk("handoff_valid", 32'(bus.mdu_res_valid), 32'd1);
        chk("handoff_stall", 32'(bus.mdu_stall), 32'd0);
        chk("handoff_no_issue", 32'(bus.mul_start), 32'd0);
        cyc();
        bus.res_ready = 1'b0;
        #1;
        chk("post_handoff_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("post_handoff_issue", 32'(bus.mul_start), 32'd1);
        cyc();
        clr();
        bus.pipe_flush = 1'b1;
        #1;
        chk("flush_busy_stall", 32'(bus.mdu_stall), 32'd1);
        cyc();
        clr();
        #1;
        chk("flushed_stall", 32'(bus.mdu_stall), 32'd0);
        chk("flushed_valid", 32'(bus.mdu_res_valid), 32'd0);
        cyc();

        // Flush coincident with div_done
        bus.ex_valid = 1'b1; bus.ex_is_div_inst = 1'b1; bus.ex_rf_waddr = 5'd3;
        cyc();
        clr();
        bus.div_done = 1'b1; bus.div_res = 32'hCAFE_0000; bus.pipe_flush = 1'b1;
        cyc();
        clr();
        #1;
        chk("flushdone_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("flushdone_stall", 32'(bus.mdu_stall), 32'd0);
        cyc();
        #1;
        chk("flushdone_valid2", 32'(bus.mdu_res_valid), 32'd0);
        cyc();

        // Both flags set: multiply wins, div_done ignored while MUL_BUSY
        bus.ex_valid = 1'b1; bus.ex_is_mul_inst = 1'b1; bus.ex_is_div_inst = 1'b1; bus.ex_rf_waddr = 5'd7;
        #1;
        chk("both_mul_start", 32'(bus.mul_start), 32'd1);
        chk("both_div_start", 32'(bus.div_start), 32'd0);
        cyc();
        clr();
        bus.div_done = 1'b1; bus.div_res = 32'h0000_0BAD;
        cyc();
        clr();
        #1;
        chk("divdone_ignored_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("divdone_ignored_stall", 32'(bus.mdu_stall), 32'd1);
        bus.mul_done = 1'b1; bus.mul_res = 32'h0000_0077;
        cyc();
        clr();
        bus.res_ready = 1'b1;
        #1;
        chk("both_valid", 32'(bus.mdu_res_valid), 32'd1);
        chk("both_res", bus.mdu_res, 32'h0000_0077);
        chk("both_rd", 32'(bus.mdu_rd_addr), 32'd7);
        cyc();
        clr();

        // Timeout: no done for 64 busy cycles
        bus.ex_valid = 1'b1; bus.ex_is_mul_inst = 1'b1; bus.ex_rf_waddr = 5'd2;
        cyc();
        clr();
        for (int k = 1; k <= 64; k++) begin
            #1;
            if (bus.mdu_err) errs++;
            if (k == 64) chk("err_at_64", 32'(bus.mdu_err), 32'd1);
            if (k == 63) chk("err_before_64", 32'(bus.mdu_err), 32'd0);
            cyc();
        end
        #1;
        chk("err_count", 32'(errs), 32'd1);
        chk("timeout_err_after", 32'(bus.mdu_err), 32'd0);
        chk("timeout_stall", 32'(bus.mdu_stall), 32'd0);
        chk("timeout_valid", 32'(bus.mdu_res_valid), 32'd0);
        cyc();

        // Asynchronous reset in DIV_BUSY
        bus.ex_valid = 1'b1; bus.ex_is_div_inst = 1'b1; bus.ex_rf_waddr = 5'd11;
        cyc();
        clr();
        #1;
        chk("pre_rst_stall", 32'(bus.mdu_stall), 32'd1);
        chk("pre_rst_rd", 32'(bus.mdu_rd_addr), 32'd11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.mdu_stall), 32'd0);
        chk("arst_res", bus.mdu_res, 32'd0);
        chk("arst_rd", 32'(bus.mdu_rd_addr), 32'd0);
        chk("arst_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("arst_err", 32'(bus.mdu_err), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.div_done = 1'b1; bus.div_res = 32'h5555_AAAA;
        cyc();
        clr();
        #1;
        chk("post_rst_done_valid", 32'(bus.mdu_res_valid), 32'd0);
        chk("post_rst_done_stall", 32'(bus.mdu_stall), 32'd0);
        chk("post_rst_res", bus.mdu_res, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
